// File: rtl/iss_pkg.sv
// iss_pkg: shared types and default widths for the ISS wakeup issue queue.
// Revision 1.0
`default_nettype none

package iss_pkg;

  localparam int DEF_DEPTH      = 16;
  localparam int DEF_TAG_W      = 6;
  localparam int DEF_PAYLOAD_W  = 104;
  localparam int DEF_WAKE_PORTS = 3;

  typedef logic [DEF_TAG_W-1:0] tag_t;

  // Entry layout at default widths; the queue re-declares it with its own parameters.
  typedef struct packed {
    logic                     valid;
    tag_t                     src1;
    logic                     src1_rdy;
    tag_t                     src2;
    logic                     src2_rdy;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } iss_entry_t;

endpackage

`default_nettype wire

// File: rtl/iss_age_select.sv
// iss_age_select: lowest-index-wins selector producing one-hot grant, index and any.
// Revision 1.0
`default_nettype none

module iss_age_select
  import iss_pkg::*;
#(
  parameter int N     = DEF_DEPTH,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  assign grant = req & (~req + N'(1));
  assign any   = |req;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/iss_wakeup_queue.sv
// iss_wakeup_queue: compacting oldest-first issue queue with tag-broadcast wakeup.
// Optional flush port enabled by defining ISSQ_FLUSH_EN. Revision 1.0
`default_nettype none

module iss_wakeup_queue
  import iss_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
  parameter int WAKE_PORTS = DEF_WAKE_PORTS,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FREEZE,
  input  logic                        push_req_IN,
  input  logic [TAG_W-1:0]            push_src1_IN,
  input  logic                        push_src1_rdy_IN,
  input  logic [TAG_W-1:0]            push_src2_IN,
  input  logic                        push_src2_rdy_IN,
  input  logic [PAYLOAD_W-1:0]        push_data_IN,
  output logic                        full_OUT,
  output logic [CNT_W-1:0]            count_OUT,
  input  logic [WAKE_PORTS-1:0]       wake_vld_IN,
  input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag_IN,
`ifdef ISSQ_FLUSH_EN
  input  logic                        flush_IN,
`endif
  output logic                        issue_vld_OUT,
  output logic [PAYLOAD_W-1:0]        issue_data_OUT
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     src1;
    logic                 src1_rdy;
    logic [TAG_W-1:0]     src2;
    logic                 src2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } q_entry_t;

  q_entry_t         q     [DEPTH];
  q_entry_t         q_nxt [DEPTH];
  q_entry_t         cur;
  logic             shift_seen;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_pos;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             do_issue;
  logic             push_acc;

  function automatic logic tag_hit(input logic [TAG_W-1:0]            tag,
                                   input logic [WAKE_PORTS-1:0]       vld,
                                   input logic [WAKE_PORTS*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = q[i].valid & q[i].src1_rdy & q[i].src2_rdy;
    end
  end

  iss_age_select #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_age_select (
    .req   (req),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign full_OUT  = (count == CNT_W'(DEPTH));
  assign count_OUT = count;
  assign do_issue  = sel_any & ~FREEZE;
  // Full is judged on the registered count, so a same-cycle issue never frees a slot.
  assign push_acc  = push_req_IN & ~full_OUT & ~FREEZE;
  assign wr_pos    = count - CNT_W'(do_issue);

  always_comb begin
    shift_seen = 1'b0;
    cur        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shift_seen = shift_seen | grant[i];
      cur        = q[i];
      if (do_issue && shift_seen) begin
        cur = (i < DEPTH - 1) ? q[IDX_W'((i + 1) % DEPTH)] : '0;
      end
      cur.src1_rdy = cur.src1_rdy | tag_hit(cur.src1, wake_vld_IN, wake_tag_IN);
      cur.src2_rdy = cur.src2_rdy | tag_hit(cur.src2, wake_vld_IN, wake_tag_IN);
      // New entries see this cycle's broadcast too, otherwise a wakeup could be missed.
      if (push_acc && (wr_pos == CNT_W'(i))) begin
        cur.valid    = 1'b1;
        cur.src1     = push_src1_IN;
        cur.src1_rdy = push_src1_rdy_IN | tag_hit(push_src1_IN, wake_vld_IN, wake_tag_IN);
        cur.src2     = push_src2_IN;
        cur.src2_rdy = push_src2_rdy_IN | tag_hit(push_src2_IN, wake_vld_IN, wake_tag_IN);
        cur.payload  = push_data_IN;
      end
      q_nxt[i] = cur;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q              <= '{default: '0};
      count          <= '0;
      issue_vld_OUT  <= 1'b0;
      issue_data_OUT <= '0;
    end
`ifdef ISSQ_FLUSH_EN
    else if (flush_IN) begin
      q             <= '{default: '0};
      count         <= '0;
      issue_vld_OUT <= 1'b0;
    end
`endif
    else if (!FREEZE) begin
      q             <= q_nxt;
      count         <= count + CNT_W'(push_acc) - CNT_W'(do_issue);
      issue_vld_OUT <= do_issue;
      if (do_issue) issue_data_OUT <= q[sel_idx].payload;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iss_wakeup_queue.sv
// tb_iss_wakeup_queue: directed stimulus with an expected-issue scoreboard and monitor.
`default_nettype none

module tb_iss_wakeup_queue;

  localparam int DEPTH = 16;
  localparam int TW    = 6;
  localparam int PW    = 104;
  localparam int WP    = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              RESET;
  logic              FREEZE;
  logic              push_req_IN;
  logic [TW-1:0]     push_src1_IN;
  logic              push_src1_rdy_IN;
  logic [TW-1:0]     push_src2_IN;
  logic              push_src2_rdy_IN;
  logic [PW-1:0]     push_data_IN;
  logic              full_OUT;
  logic [CW-1:0]     count_OUT;
  logic [WP-1:0]     wake_vld_IN;
  logic [WP*TW-1:0]  wake_tag_IN;
`ifdef ISSQ_FLUSH_EN
  logic              flush_IN;
`endif
  logic              issue_vld_OUT;
  logic [PW-1:0]     issue_data_OUT;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q [$];
  logic          mon_frz;
  logic          mon_rst;

  iss_wakeup_queue u_dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .FREEZE           (FREEZE),
    .push_req_IN      (push_req_IN),
    .push_src1_IN     (push_src1_IN),
    .push_src1_rdy_IN (push_src1_rdy_IN),
    .push_src2_IN     (push_src2_IN),
    .push_src2_rdy_IN (push_src2_rdy_IN),
    .push_data_IN     (push_data_IN),
    .full_OUT         (full_OUT),
    .count_OUT        (count_OUT),
    .wake_vld_IN      (wake_vld_IN),
    .wake_tag_IN      (wake_tag_IN),
`ifdef ISSQ_FLUSH_EN
    .flush_IN         (flush_IN),
`endif
    .issue_vld_OUT    (issue_vld_OUT),
    .issue_data_OUT   (issue_data_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [PW-1:0] pl(input int v);
    return {8'hC3, 96'(v)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic set_push(input int s1, input logic r1, input int s2, input logic r2, input int v);
    push_req_IN      = 1'b1;
    push_src1_IN     = TW'(s1);
    push_src1_rdy_IN = r1;
    push_src2_IN     = TW'(s2);
    push_src2_rdy_IN = r2;
    push_data_IN     = pl(v);
  endtask

  task automatic set_wake(input int p, input int tag);
    wake_vld_IN[p]            = 1'b1;
    wake_tag_IN[p*TW +: TW]   = TW'(tag);
  endtask

  task automatic idle();
    push_req_IN = 1'b0;
    wake_vld_IN = '0;
    wake_tag_IN = '0;
  endtask

  // Monitor: consumes one expected payload per real issue edge (frozen edges hold output).
  always @(posedge CLK) begin
    mon_frz = FREEZE;
    mon_rst = RESET;
    #1;
    if (!mon_rst && !mon_frz && issue_vld_OUT) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %0h expected none", issue_data_OUT);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (issue_data_OUT !== e) begin
          errors++;
          $display("FAIL issue_data: got %0h expected %0h", issue_data_OUT, e);
        end
      end
    end
  end

  int wt [16];

  initial begin
    RESET = 1'b1;
    FREEZE = 1'b0;
    push_src1_IN = '0; push_src1_rdy_IN = 1'b0;
    push_src2_IN = '0; push_src2_rdy_IN = 1'b0;
    push_data_IN = '0;
`ifdef ISSQ_FLUSH_EN
    flush_IN = 1'b0;
`endif
    idle();
    repeat (2) cyc();
    check("rst_count", 128'(count_OUT), 0);
    check("rst_full", 128'(full_OUT), 0);
    check("rst_issue_vld", 128'(issue_vld_OUT), 0);
    check("rst_issue_data", 128'(issue_data_OUT), 0);
    RESET = 1'b0;
    cyc();

    // Ready op into empty queue: one-edge latency
    set_push(5, 1, 6, 1, 1); exp_q.push_back(pl(1));
    cyc(); idle();
    check("t1_count_after_push", 128'(count_OUT), 1);
    check("t1_vld_after_push", 128'(issue_vld_OUT), 0);
    cyc();
    check("t1_vld_issue", 128'(issue_vld_OUT), 1);
    check("t1_count_drained", 128'(count_OUT), 0);
    cyc();
    check("t1_vld_drop", 128'(issue_vld_OUT), 0);

    // Younger ready op bypasses older waiting op
    set_push(9, 0, 1, 1, 10); cyc();
    set_push(2, 1, 3, 1, 11); exp_q.push_back(pl(11)); exp_q.push_back(pl(10));
    cyc(); idle();
    cyc();
    check("t2_b_issue", 128'(issue_vld_OUT), 1);
    check("t2_count_a_left", 128'(count_OUT), 1);
    set_wake(2, 9);
    cyc(); idle();
    check("t2_no_issue_at_wake", 128'(issue_vld_OUT), 0);
    cyc();
    check("t2_a_issue", 128'(issue_vld_OUT), 1);
    check("t2_count_empty", 128'(count_OUT), 0);

    // Wake in the same cycle as the push
    set_push(3, 1, 12, 0, 20); set_wake(0, 12); exp_q.push_back(pl(20));
    cyc(); idle();
    check("t3_vld_after_push", 128'(issue_vld_OUT), 0);
    cyc();
    check("t3_issue", 128'(issue_vld_OUT), 1);
    check("t3_count", 128'(count_OUT), 0);

    // Fill to full, refuse extra pushes, preserve order
    for (int k = 0; k < 16; k++) begin
      set_push(20 + k, 0, 7, 1, 100 + k); cyc();
    end
    idle();
    check("t4_full", 128'(full_OUT), 1);
    check("t4_count16", 128'(count_OUT), 16);
    set_push(40, 0, 7, 1, 999); cyc(); idle();
    check("t4_refused_count", 128'(count_OUT), 16);
    set_wake(0, 20); exp_q.push_back(pl(100));
    cyc(); idle();
    set_push(41, 0, 7, 1, 998);
    cyc(); idle();
    check("t4_issue_while_full", 128'(issue_vld_OUT), 1);
    check("t4_count15", 128'(count_OUT), 15);
    check("t4_not_full", 128'(full_OUT), 0);
    set_push(50, 0, 7, 1, 200);
    cyc(); idle();
    check("t4_refill_count", 128'(count_OUT), 16);
    for (int k = 0; k < 15; k++) begin
      wt[k] = 21 + k;
      exp_q.push_back(pl(101 + k));
    end
    wt[15] = 50; exp_q.push_back(pl(200));
    for (int c = 0; c < 6; c++) begin
      idle();
      for (int p = 0; p < 3; p++) if (3 * c + p < 16) set_wake(p, wt[3 * c + p]);
      cyc();
    end
    idle();
    for (int w = 0; w < 40 && count_OUT != 0; w++) cyc();
    check("t4_drained", 128'(count_OUT), 0);
    repeat (2) cyc();

    // Freeze holds everything
    set_push(60, 0, 7, 1, 300); cyc();
    set_push(61, 0, 7, 1, 301); cyc();
    set_push(62, 0, 7, 1, 302); cyc();
    idle();
    exp_q.push_back(pl(300)); exp_q.push_back(pl(301)); exp_q.push_back(pl(302));
    set_wake(0, 60); set_wake(1, 61); set_wake(2, 62);
    cyc(); idle();
    cyc();
    check("t5_pre_vld", 128'(issue_vld_OUT), 1);
    check("t5_pre_count", 128'(count_OUT), 2);
    FREEZE = 1'b1;
    set_push(1, 1, 1, 1, 997); set_wake(0, 33);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t5_frz_vld", 128'(issue_vld_OUT), 1);
      check("t5_frz_count", 128'(count_OUT), 2);
      check("t5_frz_data", 128'(issue_data_OUT), 128'(pl(300)));
    end
    FREEZE = 1'b0; idle();
    cyc();
    check("t5_resume_count", 128'(count_OUT), 1);
    cyc();
    check("t5_resume_count2", 128'(count_OUT), 0);
    cyc();
    check("t5_idle_vld", 128'(issue_vld_OUT), 0);

`ifdef ISSQ_FLUSH_EN
    for (int k = 0; k < 8; k++) begin
      set_push(63, 0, 7, 1, 400 + k); cyc();
    end
    idle();
    check("t6_count8", 128'(count_OUT), 8);
    flush_IN = 1'b1; set_push(1, 1, 1, 1, 499);
    cyc(); idle(); flush_IN = 1'b0;
    check("t6_flush_count", 128'(count_OUT), 0);
    check("t6_flush_vld", 128'(issue_vld_OUT), 0);
    cyc();
    check("t6_post_vld", 128'(issue_vld_OUT), 0);
`endif

    repeat (3) cyc();
    check("scoreboard_empty", 128'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
